// File: rtl/pwm_duty_decoder.sv
// ============================================================================
// Module  : pwm_duty_decoder
// Purpose : Recovers per-period high time and period length from a PWM line,
//           with stuck-line detection and glitch-period rejection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_decoder #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             sample_valid,
  output logic             locked,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic             short_period
);

  localparam logic [CNT_W-1:0] c_ones       = '1;
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_min_period = CNT_W'(MIN_PERIOD);

  typedef enum logic [1:0] {
    S_ACQUIRE = 2'd0,
    S_MEASURE = 2'd1,
    S_STUCK   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_pwm_s;
  logic             r_pwm_d;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_high_cnt;

  logic             w_rise;
  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_high_inc;

  assign w_rise     = r_pwm_s & ~r_pwm_d;
  assign w_per_inc  = (r_per_cnt  == c_ones) ? r_per_cnt  : r_per_cnt  + c_one;
  assign w_high_inc = (r_high_cnt == c_ones) ? r_high_cnt : r_high_cnt + c_one;

  // Synchronizer runs regardless of enable so edge history stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_pwm_s <= 1'b0;
      r_pwm_d <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_pwm_s <= r_sync1;
      r_pwm_d <= r_pwm_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_ACQUIRE;
      r_per_cnt    <= '0;
      r_high_cnt   <= '0;
      duty_out     <= '0;
      period_out   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      stuck_high   <= 1'b0;
      stuck_low    <= 1'b0;
      short_period <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      short_period <= 1'b0;
      if (!enable) begin
        // duty_out/period_out intentionally keep the last measurement.
        r_state    <= S_ACQUIRE;
        r_per_cnt  <= '0;
        r_high_cnt <= '0;
        locked     <= 1'b0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else begin
        case (r_state)
          S_ACQUIRE: begin
            if (w_rise) begin
              r_state    <= S_MEASURE;
              r_per_cnt  <= c_one;
              r_high_cnt <= c_one;
            end else begin
              r_per_cnt  <= '0;
              r_high_cnt <= '0;
            end
          end
          S_MEASURE: begin
            if (w_rise) begin
              r_per_cnt  <= c_one;
              r_high_cnt <= c_one;
              if (r_per_cnt >= c_min_period) begin
                period_out   <= r_per_cnt;
                duty_out     <= r_high_cnt;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
              end else begin
                short_period <= 1'b1;
              end
            end else if (r_per_cnt == c_timeout) begin
              r_state      <= S_STUCK;
              locked       <= 1'b0;
              period_out   <= c_ones;
              duty_out     <= r_pwm_s ? c_ones : '0;
              sample_valid <= 1'b1;
              stuck_high   <= r_pwm_s;
              stuck_low    <= ~r_pwm_s;
            end else begin
              r_per_cnt <= w_per_inc;
              if (r_pwm_s) begin
                r_high_cnt <= w_high_inc;
              end
            end
          end
          S_STUCK: begin
            if (w_rise) begin
              r_state    <= S_MEASURE;
              r_per_cnt  <= c_one;
              r_high_cnt <= c_one;
              stuck_high <= 1'b0;
              stuck_low  <= 1'b0;
            end else begin
              stuck_high <= r_pwm_s;
              stuck_low  <= ~r_pwm_s;
            end
          end
          default: begin
            r_state <= S_ACQUIRE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
// ============================================================================
// Module  : tb_pwm_duty_decoder
// Purpose : Directed self-checking bench for pwm_duty_decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic        enable;

  logic [15:0] a_duty_out, a_period_out;
  logic        a_sample_valid, a_locked, a_stuck_high, a_stuck_low, a_short_period;
  logic [15:0] b_duty_out, b_period_out;
  logic        b_sample_valid, b_locked, b_stuck_high, b_stuck_low, b_short_period;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int na    = 0;
  int nb    = 0;
  int ns_a  = 0;
  int a_times [0:63];
  int na0, nb0, ns0;

  always #5 clk = ~clk;

  // Long-timeout instance: used for period/duty measurements.
  pwm_duty_decoder #(.CNT_W(16), .TIMEOUT(65535), .MIN_PERIOD(4)) dut_a (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
    .duty_out(a_duty_out), .period_out(a_period_out),
    .sample_valid(a_sample_valid), .locked(a_locked),
    .stuck_high(a_stuck_high), .stuck_low(a_stuck_low),
    .short_period(a_short_period)
  );

  // Short-timeout instance: used for stuck-line checks.
  pwm_duty_decoder #(.CNT_W(16), .TIMEOUT(200), .MIN_PERIOD(4)) dut_b (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
    .duty_out(b_duty_out), .period_out(b_period_out),
    .sample_valid(b_sample_valid), .locked(b_locked),
    .stuck_high(b_stuck_high), .stuck_low(b_stuck_low),
    .short_period(b_short_period)
  );

  always @(posedge clk) begin
    cyc++;
    #2;
    if (a_sample_valid) begin
      if (na < 64) a_times[na] = cyc;
      na++;
    end
    if (a_short_period) ns_a++;
    if (b_sample_valid) nb++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_period(input int p, input int h);
    pwm_in = 1'b1;
    cycles(h);
    pwm_in = 1'b0;
    cycles(p - h);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    cycles(4);
    chk("rst_duty",   a_duty_out,     0);
    chk("rst_period", a_period_out,   0);
    chk("rst_valid",  a_sample_valid, 0);
    chk("rst_locked", a_locked,       0);
    chk("rst_sh",     a_stuck_high,   0);
    chk("rst_sl",     a_stuck_low,    0);
    chk("rst_short",  a_short_period, 0);
    reset = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles(2);

    // 5 periods of 100/25: first rise only starts timing
    repeat (5) pwm_period(100, 25);
    chk("p100_count_a", na, 4);
    chk("p100_count_b", nb, 4);
    for (int i = 0; i < 3; i++) chk("p100_spacing", a_times[i+1] - a_times[i], 100);
    chk("p100_period", a_period_out, 100);
    chk("p100_duty",   a_duty_out,   25);
    chk("p100_locked", a_locked,     1);
    chk("p100_noshort", ns_a,        0);

    // duty sweep at period 256
    pwm_period(256, 1);
    pwm_period(256, 128);
    chk("sw1_period", a_period_out, 256);
    chk("sw1_duty",   a_duty_out,   1);
    pwm_period(256, 255);
    chk("sw128_period", a_period_out, 256);
    chk("sw128_duty",   a_duty_out,   128);
    pwm_period(100, 25);
    chk("sw255_period", a_period_out, 256);
    chk("sw255_duty",   a_duty_out,   255);
    pwm_period(100, 25);
    pwm_period(100, 25);
    chk("relock_b", b_locked, 1);
    chk("relock_a_period", a_period_out, 100);

    // stuck low on the TIMEOUT=200 instance
    nb0 = nb;
    pwm_in = 1'b1;
    cycles(25);
    pwm_in = 1'b0;
    cycles(177);
    chk("sl_early_flag",  b_stuck_low,    0);
    chk("sl_early_valid", b_sample_valid, 0);
    cycles(1);
    chk("sl_flag",   b_stuck_low,    1);
    chk("sl_sh",     b_stuck_high,   0);
    chk("sl_valid",  b_sample_valid, 1);
    chk("sl_duty",   b_duty_out,     0);
    chk("sl_period", b_period_out,   16'hFFFF);
    chk("sl_locked", b_locked,       0);
    cycles(50);
    chk("sl_one_strobe", nb, nb0 + 2);
    chk("sl_hold", b_stuck_low, 1);
    pwm_in = 1'b1;
    cycles(3);
    chk("sl_clear",       b_stuck_low, 0);
    chk("sl_clear_lock",  b_locked,    0);
    cycles(22);
    pwm_in = 1'b0;
    cycles(75);
    pwm_in = 1'b1;
    cycles(3);
    chk("sl_relock",  b_locked,       1);
    chk("sl_rperiod", b_period_out,   100);
    chk("sl_rduty",   b_duty_out,     25);
    chk("sl_rvalid",  b_sample_valid, 1);

    // stuck high, then drop the line
    cycles(199);
    chk("sh_early", b_stuck_high, 0);
    cycles(1);
    chk("sh_flag",   b_stuck_high,   1);
    chk("sh_sl",     b_stuck_low,    0);
    chk("sh_duty",   b_duty_out,     16'hFFFF);
    chk("sh_period", b_period_out,   16'hFFFF);
    chk("sh_valid",  b_sample_valid, 1);
    pwm_in = 1'b0;
    cycles(2);
    chk("sh_drop_early", b_stuck_high, 1);
    cycles(1);
    chk("sh_drop_sh", b_stuck_high, 0);
    chk("sh_drop_sl", b_stuck_low,  1);

    // 2-cycle glitch between periods of 50
    pwm_period(50, 10);
    pwm_period(50, 10);
    na0 = na;
    ns0 = ns_a;
    pwm_period(2, 1);
    pwm_period(48, 10);
    chk("gl_valid_cnt", na,   na0 + 1);
    chk("gl_short_cnt", ns_a, ns0 + 1);
    chk("gl_period50",  a_period_out, 50);
    chk("gl_duty10",    a_duty_out,   10);
    pwm_in = 1'b1;
    cycles(3);
    chk("gl_valid48",  a_sample_valid, 1);
    chk("gl_period48", a_period_out,   48);
    chk("gl_duty48",   a_duty_out,     10);

    // enable dropped at cycle 40 of a period
    cycles(7);
    pwm_in = 1'b0;
    cycles(30);
    enable = 1'b0;
    na0 = na;
    cycles(3);
    chk("en_locked", a_locked,     0);
    chk("en_period", a_period_out, 48);
    chk("en_duty",   a_duty_out,   10);
    cycles(10);
    pwm_in = 1'b1;
    cycles(5);
    chk("en_nostrobe", na, na0);
    enable = 1'b1;
    cycles(10);
    pwm_in = 1'b0;
    cycles(20);
    pwm_in = 1'b1;
    cycles(3);
    chk("en_first_rise", a_sample_valid, 0);
    chk("en_first_cnt",  na,             na0);
    cycles(7);
    pwm_in = 1'b0;
    cycles(40);
    pwm_in = 1'b1;
    cycles(3);
    chk("en_resume_valid",  a_sample_valid, 1);
    chk("en_resume_period", a_period_out,   50);
    chk("en_resume_locked", a_locked,       1);

    // reset mid-period
    cycles(20);
    pwm_in = 1'b0;
    reset  = 1'b1;
    cycles(1);
    chk("mrst_duty",   a_duty_out,     0);
    chk("mrst_period", a_period_out,   0);
    chk("mrst_locked", a_locked,       0);
    chk("mrst_valid",  a_sample_valid, 0);
    chk("mrst_bper",   b_period_out,   0);
    reset = 1'b0;
    cycles(10);
    na0 = na;
    pwm_in = 1'b1;
    cycles(3);
    chk("mrst_first_rise", a_sample_valid, 0);
    cycles(2);
    chk("mrst_cnt",    na,       na0);
    chk("mrst_locked2", a_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
